clk_rst_gen: RTL and testbench
==============================

// Module: clk_rst_gen
// PURPOSE
//   Board-level clock/reset front end for the Basys3 top level. Buffers the
//   external 100 MHz oscillator onto the global clock net as clk_100m00.
//   Produces rst_100m00, a clean active-high reset for all 100 MHz logic:
//   asserted asynchronously, released synchronously after a programmable hold.
// PARAMETERS
//   RST_LENGTH   10  clk_100m00 cycles rst_100m00 stays high after sync release; legal 1..2^16-1
//   SYNC_STAGES  2   reset synchronizer depth; legal 2..4
//   USE_BUFG     1   1: route clock through Xilinx BUFG; 0: plain wire (sim/non-Xilinx)
// PORTS
//   clk_ext      in   1  external 100 MHz oscillator (sole clock input)
//   rst_ext      in   1  external reset, asynchronous, active-low (0 = reset)
//   clk_100m00   out  1  buffered 100 MHz system clock, same frequency/phase as clk_ext
//   rst_100m00   out  1  system reset, active-high, synchronous to clk_100m00 on release
// BEHAVIOUR
//   - Clock: clk_100m00 = clk_ext via BUFG (or wire); no division, gating or PLL;
//     zero-delay pass-through in simulation.
//   - All reset flops are clocked by clk_100m00, async-cleared/preset by rst_ext=0.
//   - Assertion: rst_ext falling drives rst_100m00=1 immediately (combinational
//     path through async preset only, no clock required); sync chain and hold
//     counter cleared to their reset values at the same time.
//   - Release: after rst_ext rises, a '1' shifts through SYNC_STAGES flops;
//     then a hold counter (width $clog2(RST_LENGTH+1)) counts RST_LENGTH edges.
//     rst_100m00 falls on rising edge number SYNC_STAGES+RST_LENGTH counted from
//     the first clk_100m00 rising edge strictly after rst_ext rises.
//   - rst_100m00 is driven directly from a flop (glitch-free, no comb output).
//   - Reset at power-up/initial: all flops init so rst_100m00=1 (INIT/initial
//     value 1) even before any rst_ext activity; with rst_ext held high from
//     time 0, release follows the same SYNC_STAGES+RST_LENGTH edge count.
//   - rst_ext re-asserted mid-hold or mid-sync: immediate restart; rst_100m00
//     stays 1, count restarts from zero on next release (no partial credit).
//   - rst_ext pulses shorter than one clock period still assert rst_100m00
//     and force a full SYNC_STAGES+RST_LENGTH release sequence.
//   - Once released, rst_100m00 stays 0 until rst_ext goes low again; counter
//     saturates (no wrap, no re-assertion).
//   - Sync flops carry ASYNC_REG attribute.
// STRUCTURE
//   - No package needed; parameters local to this block.
//   - One sub-module natural: rst_sync (SYNC_STAGES-deep async-assert/sync-
//     release synchronizer, active-low in, active-high out). Hold counter and
//     BUFG/wire select live in clk_rst_gen.
// TESTING  (T=10 ns, clk_ext starts 0, rises at 5,15,25 ns...; defaults)
//   - rst_ext=0 from t=0 -> rst_100m00=1 throughout; clk_100m00 toggles in
//     lockstep with clk_ext.
//   - rst_ext rises at 350 ns -> rst_100m00 stays 1 through 455 ns edge, falls
//     on 465 ns edge (2+10=12th edge), stays 0 thereafter.
//   - rst_ext falls at 1120 ns (between edges) -> rst_100m00=1 at 1120 ns,
//     before the 1125 ns edge.
//   - rst_ext low again 2 ns at 402 ns, during hold -> rst_100m00 held 1; falls
//     12 edges after 404 ns, i.e. on 515 ns edge.
//   - RST_LENGTH=1, SYNC_STAGES=3 -> release on 4th edge after rst_ext rise.
//   - rst_ext held 1 from t=0 -> rst_100m00=1 at t=0, falls on 115 ns edge.

Source files
------------

// File: rtl/clk_rst_gen_pkg.sv
// Shared types and helpers for the board clock/reset front end.
package clk_rst_gen_pkg;

  typedef enum logic [1:0] {
    REL_SYNC = 2'd0,
    REL_HOLD = 2'd1,
    REL_DONE = 2'd2
  } rel_state_e;

  function automatic int hold_cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/clk_rst_gen_rst_sync.sv
// Async-assert / sync-release reset synchronizer.
// Input is active-low; the output is active-high.
module clk_rst_gen_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_o
);

  // Power-up value matches the async-reset value, so the chain starts "in reset".
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q = '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_o = ~sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_gen.sv
// Basys3 clock/reset front end: buffers the 100 MHz oscillator and produces a
// clean active-high reset that is released after a programmable hold.
//
//   state    | meaning
//   REL_SYNC | waiting for the synchronizer to release
//   REL_HOLD | hold counter running, rst_100m00 still high
//   REL_DONE | reset released; counter saturated
module clk_rst_gen
  import clk_rst_gen_pkg::*;
#(
  parameter int RST_LENGTH  = 10,
  parameter int SYNC_STAGES = 2,
  parameter int USE_BUFG    = 1
) (
  input  logic clk_ext,
  input  logic rst_ext,
  output logic clk_100m00,
  output logic rst_100m00
);

  localparam int CNT_W = hold_cnt_width(RST_LENGTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_LENGTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (USE_BUFG != 0) begin : g_bufg
    (* clock_buffer_type = "BUFG" *) logic clk_buf;
    assign clk_buf    = clk_ext;
    assign clk_100m00 = clk_buf;
  end else begin : g_wire
    assign clk_100m00 = clk_ext;
  end

  logic sync_rst;

  clk_rst_gen_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk_i   (clk_100m00),
    .rst_n_i (rst_ext),
    .rst_o   (sync_rst)
  );

  // Initializers give the power-up state, identical to the async-reset state.
  rel_state_e       state_q = REL_SYNC;
  rel_state_e       state_d;
  logic [CNT_W-1:0] cnt_q   = CNT_LOAD;
  logic [CNT_W-1:0] cnt_d;
  logic             rst_q   = 1'b1;
  logic             rst_d;

  always_ff @(posedge clk_100m00 or negedge rst_ext) begin
    if (!rst_ext) begin
      state_q <= REL_SYNC;
      cnt_q   <= CNT_LOAD;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    unique case (state_q)
      REL_SYNC: begin
        if (!sync_rst) begin
          if (cnt_q == CNT_ONE) begin
            cnt_d   = '0;
            rst_d   = 1'b0;
            state_d = REL_DONE;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
            state_d = REL_HOLD;
          end
        end
      end
      REL_HOLD: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          rst_d   = 1'b0;
          state_d = REL_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      REL_DONE: begin
        rst_d = 1'b0;
      end
      default: begin
        state_d = REL_SYNC;
        cnt_d   = CNT_LOAD;
        rst_d   = 1'b1;
      end
    endcase
  end

  assign rst_100m00 = rst_q;

endmodule

// File: tb/tb_clk_rst_gen.sv
// Randomized bench for clk_rst_gen: two parameterizations share one rst_ext,
// checked against an edge-counting reference model via scoreboard queues.
`timescale 1ns/1ps
module tb_clk_rst_gen;

  localparam int S_A = 2;
  localparam int L_A = 10;
  localparam int S_B = 3;
  localparam int L_B = 1;

  logic clk_ext = 1'b0;
  logic rst_ext = 1'b1;
  logic clk_a, rst_a, clk_b, rst_b;

  clk_rst_gen dut_a (
    .clk_ext    (clk_ext),
    .rst_ext    (rst_ext),
    .clk_100m00 (clk_a),
    .rst_100m00 (rst_a)
  );

  clk_rst_gen #(
    .RST_LENGTH  (L_B),
    .SYNC_STAGES (S_B),
    .USE_BUFG    (0)
  ) dut_b (
    .clk_ext    (clk_ext),
    .rst_ext    (rst_ext),
    .clk_100m00 (clk_b),
    .rst_100m00 (rst_b)
  );

  always #5 clk_ext = ~clk_ext;

  int   vectors     = 0;
  int   miscompares = 0;
  bit   exp_a_q[$];
  bit   exp_b_q[$];
  bit   async_q[$];
  event ev_async;

  // Reference model: number of rising edges seen since rst_ext last went high.
  int edges    = 0;
  bit low_seen = 1'b0;

  always @(posedge clk_ext) begin
    if (!rst_ext) begin
      edges    = 0;
      low_seen = 1'b1;
    end else if (low_seen) begin
      edges    = 1;
      low_seen = 1'b0;
    end else if (edges < 1000000) begin
      edges++;
    end
    exp_a_q.push_back(!rst_ext || (edges < S_A + L_A));
    exp_b_q.push_back(!rst_ext || (edges < S_B + L_B));
  end

  task automatic check(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk_ext) begin
    bit e;
    #1;
    if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty at %0t: got no expectation expected one", $time);
    end else begin
      e = exp_a_q.pop_front();
      check("rst_a_edge", rst_a, e);
      e = exp_b_q.pop_front();
      check("rst_b_edge", rst_b, e);
    end
    check("clk_a_high", clk_a, 1'b1);
    check("clk_b_high", clk_b, 1'b1);
  end

  always @(negedge clk_ext) begin
    #1;
    check("clk_a_low", clk_a, 1'b0);
    check("clk_b_low", clk_b, 1'b0);
  end

  always @(ev_async) begin
    bit e;
    #1;
    if (async_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL async_empty at %0t: got no expectation expected one", $time);
    end else begin
      e = async_q.pop_front();
      check("rst_a_async", rst_a, e);
      check("rst_b_async", rst_b, e);
    end
  end

  task automatic drive_low();
    rst_ext  = 1'b0;
    low_seen = 1'b1;
    async_q.push_back(1'b1);
    -> ev_async;
  endtask

  task automatic at_time(input longint t);
    #(t - $time);
  endtask

  // Keeps rst_ext edges away from the clock edge and the sample point.
  task automatic safe_delay(input int ns);
    longint ph;
    #(ns);
    ph = $time % 10;
    while (ph == 4 || ph == 5 || ph == 6) begin
      #1;
      ph = $time % 10;
    end
  endtask

  initial begin
    #1;
    async_q.push_back(1'b1);
    -> ev_async;
    at_time(202);
    drive_low();
    at_time(350);
    rst_ext = 1'b1;
    at_time(402);
    drive_low();
    at_time(404);
    rst_ext = 1'b1;
    at_time(1120);
    drive_low();
    at_time(1133);
    rst_ext = 1'b1;
    safe_delay(200);
    for (int i = 0; i < 60; i++) begin
      drive_low();
      if ($urandom_range(0, 2) == 0) safe_delay($urandom_range(1, 3));
      else safe_delay($urandom_range(5, 60));
      rst_ext = 1'b1;
      safe_delay($urandom_range(20, 250));
    end
    safe_delay(300);
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
